elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
- Sequential motion controller for the two-car elevator system; consumes the per-car turn flags and produces the car positions and direction bits that the turn-decision logic reads.
- Per car, steps floor-by-floor with timed travel and door dwell, and serves hall and car calls.
- Emits one-cycle served pulses so the request registers can clear answered calls.
- Floors are indexed 0..NUM_FLOORS-1; bit i of every bitmap means floor i.

Parameters:
- NUM_FLOORS, 7, number of floors and bitmap width.
- FLOOR_W, 3, floor index width.
- MOVE_CYCLES, 4, cycles spent travelling between adjacent floors (must be >= 1).
- DOOR_CYCLES, 3, cycles the door stays open per stop (must be >= 1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- turn  in  2  turn request; bit1 = car 1, bit0 = car 2
- up_passenger  in  NUM_FLOORS  pending up hall calls
- down_passenger  in  NUM_FLOORS  pending down hall calls
- car_call_1, car_call_2  in  NUM_FLOORS  in-car destination requests per car
- curr_elevator_1, curr_elevator_2  out  FLOOR_W  current floor per car
- dir_elevator  out  2  direction; bit1 = car 1, bit0 = car 2; 1 = up, 0 = down
- door_open  out  2  door state; bit1 = car 1, bit0 = car 2
- served_up, served_down  out  NUM_FLOORS  one-cycle pulse: hall call at that floor answered
- car_served_1, car_served_2  out  NUM_FLOORS  one-cycle pulse: car call answered

Behaviour:
- Reset (async, rst_n = 0): car 1 at floor 0, direction up; car 2 at floor NUM_FLOORS-1, direction down (dir_elevator = 2'b10). Both cars IDLE, door_open = 0, all served pulses 0, counters 0.
- Per-car FSM with states IDLE, MOVE, DOOR.
- Definitions at floor f, direction d:
  - stop_here: (d ? up_passenger[f] : down_passenger[f]) | car_call[f].
  - ahead: any bit of (up | down | car_call) strictly above f when d = up, strictly below f when d = down.
- IDLE, evaluated in strict priority:
  - stop_here: go to DOOR, door_open = 1, load dwell counter with DOOR_CYCLES-1. Pulse the matching served_up/served_down bit and car_served bit in the same cycle door_open rises.
  - else turn bit = 1: flip d; remain IDLE one cycle.
  - else at end floor (f = NUM_FLOORS-1 with d up, or f = 0 with d down): flip d regardless of turn.
  - else ahead: go to MOVE, load move counter with MOVE_CYCLES-1.
  - else hold.
- MOVE: decrement counter each cycle; when it reads 0, update f by +1 or -1 and return to IDLE. Per-floor step is MOVE_CYCLES+1 cycles including the IDLE decision cycle. Floor never leaves 0..NUM_FLOORS-1.
- DOOR: decrement counter; when it reads 0, door_open = 0 and return to IDLE. Requests arriving during DOOR are evaluated on return to IDLE.
- Simultaneous hall service: if both cars would serve the same hall bit in the same cycle, car 1 wins. Car 2 treats that hall bit as clear for that cycle and stops only if it has its own car call there.
- A turn asserted while in MOVE or DOOR is ignored.
- A call withdrawn mid-MOVE does not abort the step; the car still completes the floor step.
- Reset mid-operation returns both cars to reset floors immediately. Served pulses are never generated by reset.
- All outputs are registered.

Decomposition:
- Shared package elevator_pkg holds:
  - NUM_FLOORS, FLOOR_W.
  - Car state enum {IDLE, MOVE, DOOR}.
  - DIR_UP = 1, DIR_DOWN = 0.
  - Reset floor/direction constants per car.
- Natural sub-module: elevator_car_fsm (one car: FSM, counters, floor, direction, stop/ahead evaluation), instantiated twice.
- Top level handles the car-1 priority mask and merges the served bitmaps by OR.

Test Plan:
- Reset: check curr_elevator_1 = 0, curr_elevator_2 = 6, dir_elevator = 2'b10, door_open = 0, all served = 0.
- up_passenger = 7'b0001000, defaults, car 2 otherwise idle:
  - car 1 reaches floor 3 after 15 cycles (3 steps x 5 cycles);
  - door_open[1] rises next cycle with served_up[3] pulsed exactly one cycle;
  - door stays open 3 cycles.
- Car 1 idle at floor 2 going up, no requests, turn = 2'b10 for one cycle: dir_elevator[1] becomes 0 on the next edge, floor unchanged, no door.
- Both cars at floor 3 with dir_elevator = 2'b11 and up_passenger[3] = 1: only car 1 opens and pulses served_up[3]; car 2 does not open.
- Car 1 at floor 6 going up, no requests, turn = 0: direction forced to down in one cycle.
- Assert rst_n = 0 mid-MOVE (counter = 2): outputs return to reset values asynchronously. After release, no served pulse appears and car 1 is at floor 0.

Source files
------------

// File: rtl/elevator_car_ctrl_pkg.sv
// Shared constants and types for the two-car elevator motion controller.
package elevator_pkg;
    localparam int NUM_FLOORS = 7;
    localparam int FLOOR_W    = 3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} car_state_t;

    localparam logic [FLOOR_W-1:0] CAR1_RST_FLOOR = '0;
    localparam logic [FLOOR_W-1:0] CAR2_RST_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic               CAR1_RST_DIR   = DIR_UP;
    localparam logic               CAR2_RST_DIR   = DIR_DOWN;
endpackage

// File: rtl/elevator_car_ctrl_if.sv
// Request/status bundle between the request registers and the car controller.
interface elevator_car_ctrl_if;
    import elevator_pkg::*;

    // No backpressure: request bitmaps are levels; served_* are one-cycle pulses
    // the request side must consume on the cycle they are high.
    logic [1:0]            turn;
    logic [NUM_FLOORS-1:0] up_passenger;
    logic [NUM_FLOORS-1:0] down_passenger;
    logic [NUM_FLOORS-1:0] car_call_1;
    logic [NUM_FLOORS-1:0] car_call_2;
    logic [FLOOR_W-1:0]    curr_elevator_1;
    logic [FLOOR_W-1:0]    curr_elevator_2;
    logic [1:0]            dir_elevator;
    logic [1:0]            door_open;
    logic [NUM_FLOORS-1:0] served_up;
    logic [NUM_FLOORS-1:0] served_down;
    logic [NUM_FLOORS-1:0] car_served_1;
    logic [NUM_FLOORS-1:0] car_served_2;
    car_state_t            state_1;
    car_state_t            state_2;

    modport master (
        output turn, up_passenger, down_passenger, car_call_1, car_call_2,
        input  curr_elevator_1, curr_elevator_2, dir_elevator, door_open,
        input  served_up, served_down, car_served_1, car_served_2, state_1, state_2
    );

    modport slave (
        input  turn, up_passenger, down_passenger, car_call_1, car_call_2,
        output curr_elevator_1, curr_elevator_2, dir_elevator, door_open,
        output served_up, served_down, car_served_1, car_served_2, state_1, state_2
    );
endinterface

// File: rtl/elevator_car_fsm.sv
// One elevator car: IDLE/MOVE/DOOR sequencing, travel and dwell timing, floor and direction.
module elevator_car_fsm
    import elevator_pkg::*;
#(
    parameter int                 MOVE_CYCLES = 4,
    parameter int                 DOOR_CYCLES = 3,
    parameter logic [FLOOR_W-1:0] RST_FLOOR   = '0,
    parameter logic               RST_DIR     = DIR_UP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  turn,
    input  logic [NUM_FLOORS-1:0] up_req,
    input  logic [NUM_FLOORS-1:0] down_req,
    input  logic [NUM_FLOORS-1:0] car_call,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] served_up,
    output logic [NUM_FLOORS-1:0] served_down,
    output logic [NUM_FLOORS-1:0] car_served,
    output car_state_t            state
);
    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    car_state_t            state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [FLOOR_W-1:0]    floor_d;
    logic                  dir_d;
    logic [NUM_FLOORS-1:0] served_up_d, served_down_d, car_served_d;
    logic [NUM_FLOORS-1:0] floor_bit, all_req, above_mask, below_mask, hall_dir;
    logic                  stop_here, ahead, at_end;

    assign floor_bit  = NUM_FLOORS'(1) << floor;
    assign all_req    = up_req | down_req | car_call;
    // Masks exclude the current floor itself: "ahead" means strictly beyond it.
    assign above_mask = ~((floor_bit << 1) - NUM_FLOORS'(1));
    assign below_mask = floor_bit - NUM_FLOORS'(1);
    assign hall_dir   = (dir == DIR_UP) ? up_req : down_req;
    assign stop_here  = |(floor_bit & (hall_dir | car_call));
    assign ahead      = (dir == DIR_UP) ? |(all_req & above_mask) : |(all_req & below_mask);
    assign at_end     = (dir == DIR_UP) ? (floor == FLOOR_W'(NUM_FLOORS - 1)) : (floor == '0);
    assign door_open  = (state == DOOR);

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        floor_d       = floor;
        dir_d         = dir;
        served_up_d   = '0;
        served_down_d = '0;
        car_served_d  = '0;
        case (state)
            IDLE: begin
                if (stop_here) begin
                    state_d       = DOOR;
                    cnt_d         = CNT_W'(DOOR_CYCLES - 1);
                    served_up_d   = (dir == DIR_UP) ? (floor_bit & up_req) : '0;
                    served_down_d = (dir == DIR_DOWN) ? (floor_bit & down_req) : '0;
                    car_served_d  = floor_bit & car_call;
                end else if (turn || at_end) begin
                    dir_d = ~dir;
                end else if (ahead) begin
                    state_d = MOVE;
                    cnt_d   = CNT_W'(MOVE_CYCLES - 1);
                end
            end
            MOVE: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                    floor_d = (dir == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DOOR: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            floor       <= RST_FLOOR;
            dir         <= RST_DIR;
            served_up   <= '0;
            served_down <= '0;
            car_served  <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            floor       <= floor_d;
            dir         <= dir_d;
            served_up   <= served_up_d;
            served_down <= served_down_d;
            car_served  <= car_served_d;
        end
    end
endmodule

// File: rtl/elevator_car_ctrl.sv
// Two-car motion controller: two car FSMs, car-1 hall priority, merged served pulses.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    elevator_car_ctrl_if.slave bus
);
    logic [FLOOR_W-1:0]    floor_1, floor_2;
    logic                  dir_1, dir_2, door_1, door_2;
    logic [NUM_FLOORS-1:0] su_1, sd_1, su_2, sd_2, cs_1, cs_2;
    logic [NUM_FLOORS-1:0] floor_bit_1, take_up, take_down;
    car_state_t            state_1, state_2;

    // Car 1 stops for its direction's hall bit whenever it is deciding in IDLE,
    // so that bit is hidden from car 2 in the same cycle.
    assign floor_bit_1 = NUM_FLOORS'(1) << floor_1;
    assign take_up     = (state_1 == IDLE && dir_1 == DIR_UP) ? (floor_bit_1 & bus.up_passenger) : '0;
    assign take_down   = (state_1 == IDLE && dir_1 == DIR_DOWN) ? (floor_bit_1 & bus.down_passenger) : '0;

    elevator_car_fsm #(
        .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES),
        .RST_FLOOR(CAR1_RST_FLOOR), .RST_DIR(CAR1_RST_DIR)
    ) u_car_1 (
        .clk(clk), .rst_n(rst_n), .turn(bus.turn[1]),
        .up_req(bus.up_passenger), .down_req(bus.down_passenger), .car_call(bus.car_call_1),
        .floor(floor_1), .dir(dir_1), .door_open(door_1),
        .served_up(su_1), .served_down(sd_1), .car_served(cs_1), .state(state_1)
    );

    elevator_car_fsm #(
        .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES),
        .RST_FLOOR(CAR2_RST_FLOOR), .RST_DIR(CAR2_RST_DIR)
    ) u_car_2 (
        .clk(clk), .rst_n(rst_n), .turn(bus.turn[0]),
        .up_req(bus.up_passenger & ~take_up), .down_req(bus.down_passenger & ~take_down),
        .car_call(bus.car_call_2),
        .floor(floor_2), .dir(dir_2), .door_open(door_2),
        .served_up(su_2), .served_down(sd_2), .car_served(cs_2), .state(state_2)
    );

    assign bus.curr_elevator_1 = floor_1;
    assign bus.curr_elevator_2 = floor_2;
    assign bus.dir_elevator    = {dir_1, dir_2};
    assign bus.door_open       = {door_1, door_2};
    assign bus.served_up       = su_1 | su_2;
    assign bus.served_down     = sd_1 | sd_2;
    assign bus.car_served_1    = cs_1;
    assign bus.car_served_2    = cs_2;
    assign bus.state_1         = state_1;
    assign bus.state_2         = state_2;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: timestamp-based car model, per-cycle scoreboard, directed pins.
module tb_elevator_car_ctrl;
    import elevator_pkg::*;

    localparam int MOVE_CYCLES = 4;
    localparam int DOOR_CYCLES = 3;
    localparam int NF = NUM_FLOORS;
    localparam int W  = 2 * FLOOR_W + 4 + 4 * NF;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_car_ctrl_if bus ();
    elevator_car_ctrl #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    bit check_en = 1'b0;

    // Model: each car remembers when its floor changes, when its door closes
    // and when it may next make a decision, all as edge numbers.
    int edge_n;
    int m_fl[2], m_dir[2], m_door[2], m_ready[2], m_move_at[2], m_door_end[2], m_step[2];
    logic [NF-1:0] m_su, m_sd;
    logic [NF-1:0] m_cs[2];

    task automatic model_reset();
        edge_n = 0;
        m_fl[0] = 0;  m_fl[1] = NF - 1;
        m_dir[0] = 1; m_dir[1] = 0;
        for (int c = 0; c < 2; c++) begin
            m_door[c] = 0; m_ready[c] = 1; m_move_at[c] = -1; m_door_end[c] = -1; m_step[c] = 0;
            m_cs[c] = '0;
        end
        m_su = '0; m_sd = '0;
    endtask

    task automatic model_advance();
        logic [NF-1:0] up, dn, cc, all;
        bit tb, ahead;
        int f;
        edge_n++;
        m_su = '0; m_sd = '0; m_cs[0] = '0; m_cs[1] = '0;
        up = bus.up_passenger;
        dn = bus.down_passenger;
        for (int c = 0; c < 2; c++) begin
            cc = (c == 0) ? bus.car_call_1 : bus.car_call_2;
            tb = (c == 0) ? bus.turn[1] : bus.turn[0];
            if (edge_n == m_move_at[c]) m_fl[c] += m_step[c];
            if (edge_n == m_door_end[c]) m_door[c] = 0;
            if (edge_n >= m_ready[c]) begin
                f = m_fl[c];
                all = up | dn | cc;
                ahead = 0;
                for (int i = 0; i < NF; i++)
                    if (all[i] && ((m_dir[c] == 1) ? (i > f) : (i < f))) ahead = 1;
                if (((m_dir[c] == 1) ? up[f] : dn[f]) || cc[f]) begin
                    m_door[c] = 1;
                    m_door_end[c] = edge_n + DOOR_CYCLES;
                    m_ready[c] = edge_n + DOOR_CYCLES + 1;
                    if (m_dir[c] == 1) begin
                        if (up[f]) m_su[f] = 1'b1;
                    end else if (dn[f]) m_sd[f] = 1'b1;
                    m_cs[c][f] = cc[f];
                    if (c == 0) begin
                        if (m_dir[0] == 1) up[f] = 1'b0;
                        else dn[f] = 1'b0;
                    end
                end else if (tb || ((m_dir[c] == 1) ? (f == NF - 1) : (f == 0))) begin
                    m_dir[c] = 1 - m_dir[c];
                    m_ready[c] = edge_n + 1;
                end else if (ahead) begin
                    m_step[c] = (m_dir[c] == 1) ? 1 : -1;
                    m_move_at[c] = edge_n + MOVE_CYCLES;
                    m_ready[c] = edge_n + MOVE_CYCLES + 1;
                end else begin
                    m_ready[c] = edge_n + 1;
                end
            end
        end
        if (check_en)
            exp_q.push_back({FLOOR_W'(m_fl[0]), FLOOR_W'(m_fl[1]), 1'(m_dir[0]), 1'(m_dir[1]),
                             1'(m_door[0]), 1'(m_door[1]), m_su, m_sd, m_cs[0], m_cs[1]});
    endtask

    // scoreboard compare, mid-cycle
    always @(negedge clk) begin
        logic [W-1:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.curr_elevator_1, bus.curr_elevator_2, bus.dir_elevator, bus.door_open,
                     bus.served_up, bus.served_down, bus.car_served_1, bus.car_served_2};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL scoreboard @%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // driver: one clock edge, then the request side drops answered calls
    task automatic cycle();
        @(posedge clk);
        model_advance();
        #1;
        bus.up_passenger   = bus.up_passenger & ~m_su;
        bus.down_passenger = bus.down_passenger & ~m_sd;
        bus.car_call_1     = bus.car_call_1 & ~m_cs[0];
        bus.car_call_2     = bus.car_call_2 & ~m_cs[1];
    endtask

    task automatic clear_inputs();
        bus.turn = '0; bus.up_passenger = '0; bus.down_passenger = '0;
        bus.car_call_1 = '0; bus.car_call_2 = '0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_curr1"}, 32'(bus.curr_elevator_1), 0);
        check({tag, "_curr2"}, 32'(bus.curr_elevator_2), 6);
        check({tag, "_dir"},   32'(bus.dir_elevator), 32'b10);
        check({tag, "_door"},  32'(bus.door_open), 0);
        check({tag, "_served"}, 32'(bus.served_up | bus.served_down | bus.car_served_1 | bus.car_served_2), 0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check_en = 1'b1;

        // Car 1 answers an up hall call at floor 3.
        bus.up_passenger = 7'b0001000;
        for (int i = 1; i <= 19; i++) begin
            cycle();
            if (i == 14) check("curr1_e14", 32'(bus.curr_elevator_1), 2);
            if (i == 15) begin
                check("curr1_e15", 32'(bus.curr_elevator_1), 3);
                check("model_fl1_e15", 32'(m_fl[0]), 3);
                check("door_e15", 32'(bus.door_open), 0);
            end
            if (i == 16) begin
                check("door_e16", 32'(bus.door_open), 32'b10);
                check("served_up_e16", 32'(bus.served_up), 32'b0001000);
                check("curr2_e16", 32'(bus.curr_elevator_2), 3);
            end
            if (i == 17) check("served_up_e17", 32'(bus.served_up), 0);
            if (i == 18) check("door_e18", 32'(bus.door_open), 32'b10);
            if (i == 19) check("door_e19", 32'(bus.door_open), 0);
        end

        // Both cars at floor 3 heading up: car 1 wins the shared hall call.
        bus.turn = 2'b01;
        cycle();
        bus.turn = 2'b00;
        cycle();
        check("dir_both_up", 32'(bus.dir_elevator), 32'b11);
        bus.up_passenger = 7'b0001000;
        cycle();
        check("prio_door", 32'(bus.door_open), 32'b10);
        check("prio_served_up", 32'(bus.served_up), 32'b0001000);
        check("prio_car2_floor", 32'(bus.curr_elevator_2), 3);
        repeat (4) cycle();

        // Idle turn flips direction without moving or opening.
        bus.turn = 2'b10;
        cycle();
        check("turn_dir", 32'(bus.dir_elevator), 32'b01);
        check("turn_floor", 32'(bus.curr_elevator_1), 3);
        check("turn_door", 32'(bus.door_open), 0);
        cycle();
        check("turn_back_dir", 32'(bus.dir_elevator), 32'b11);
        bus.turn = 2'b00;

        // Car call to the top floor, then the end-floor reversal.
        bus.car_call_1 = 7'b1000000;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (i == 15) check("top_curr1", 32'(bus.curr_elevator_1), 6);
            if (i == 16) begin
                check("top_door", 32'(bus.door_open), 32'b10);
                check("top_car_served", 32'(bus.car_served_1), 32'b1000000);
            end
            if (i == 19) check("top_dir_before", 32'(bus.dir_elevator), 32'b11);
            if (i == 20) begin
                check("top_dir_forced", 32'(bus.dir_elevator), 32'b01);
                check("top_floor_kept", 32'(bus.curr_elevator_1), 6);
            end
        end

        // Reset in the middle of a floor step.
        bus.car_call_1 = 7'b0000001;
        cycle();
        cycle();
        check("pre_reset_state", 32'(bus.state_1), 32'(MOVE));
        check("pre_reset_floor", 32'(bus.curr_elevator_1), 6);
        check_en = 1'b0;
        exp_q.delete();
        #1 rst_n = 1'b0;
        clear_inputs();
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("post_reset_served", 32'(bus.served_up | bus.served_down | bus.car_served_1 | bus.car_served_2), 0);
            check("post_reset_curr1", 32'(bus.curr_elevator_1), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.turn = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 7) == 0) bus.up_passenger   |= NF'(1) << $urandom_range(0, NF - 1);
            if ($urandom_range(0, 7) == 0) bus.down_passenger |= NF'(1) << $urandom_range(0, NF - 1);
            if ($urandom_range(0, 9) == 0) bus.car_call_1     |= NF'(1) << $urandom_range(0, NF - 1);
            if ($urandom_range(0, 9) == 0) bus.car_call_2     |= NF'(1) << $urandom_range(0, NF - 1);
            if ($urandom_range(0, 39) == 0) bus.up_passenger  &= ~(NF'(1) << $urandom_range(0, NF - 1));
            if ($urandom_range(0, 39) == 0) bus.car_call_2    &= ~(NF'(1) << $urandom_range(0, NF - 1));
            cycle();
        end
        bus.turn = 2'b00;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
